// File: rtl/craft_rc_pkg.sv
// Shared definitions for the CRAFT round-constant sequencer.
// Holds the default LFSR geometry, taps and seeds, the sequencer state type, and
// lfsr_advance, which steps a Fibonacci LFSR n times at elaboration time. The
// sequencer uses it to derive the inverse-run start values.
package craft_rc_pkg;

  localparam int unsigned DefAW     = 4;
  localparam int unsigned DefBW     = 3;
  localparam logic [3:0]  DefATaps  = 4'b0011;
  localparam logic [2:0]  DefBTaps  = 3'b011;
  localparam logic [3:0]  DefASeed  = 4'h1;
  localparam logic [2:0]  DefBSeed  = 3'h1;
  localparam int unsigned DefRounds = 32;

  typedef enum logic {StIdle, StRun} seq_state_e;

  // Forward Fibonacci step, repeated n times: new MSB = ^(x & taps), rest shifts right.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] seed,
                                               input logic [31:0] taps,
                                               input int unsigned width,
                                               input int unsigned n);
    logic [31:0] mask;
    logic [31:0] x;
    logic        fb;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    x    = seed & mask;
    for (int unsigned i = 0; i < n; i++) begin
      fb = ^(x & taps);
      x  = ((x >> 1) | ({31'd0, fb} << (width - 1))) & mask;
    end
    return x;
  endfunction

endpackage

// File: rtl/craft_rc_sequencer_if.sv
// Handshake bundle between the round-constant sequencer and the round pipeline.
// master: sequencer side (drives rc_valid, rc_data, rc_last, round_idx, busy, done;
//         receives start, dir, rc_ready).
// slave:  consumer/controller side (the mirror image).
interface craft_rc_sequencer_if
  import craft_rc_pkg::*;
#(
  parameter int unsigned RcW  = DefAW + 1 + DefBW,
  parameter int unsigned CntW = 5
) ();

  logic            start;
  logic            dir;
  logic            rc_valid;
  logic            rc_ready;
  logic [RcW-1:0]  rc_data;
  logic            rc_last;
  logic [CntW-1:0] round_idx;
  logic            busy;
  logic            done;

  modport master (
    input  start, dir, rc_ready,
    output rc_valid, rc_data, rc_last, round_idx, busy, done
  );

  modport slave (
    output start, dir, rc_ready,
    input  rc_valid, rc_data, rc_last, round_idx, busy, done
  );

endinterface

// File: rtl/craft_lfsr_step.sv
// Combinational one-step Fibonacci LFSR, both directions.
// x_i   current state
// fwd_o forward successor: {^(x & TAPS), x[W-1:1]}
// inv_o predecessor; requires TAPS[0] == 1 so the dropped bit can be recovered.
module craft_lfsr_step #(
  parameter int unsigned  W    = 4,
  parameter logic [W-1:0] TAPS = W'(1)
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] fwd_o,
  output logic [W-1:0] inv_o
);

  logic [W-1:0] p_shift;

  always_comb begin
    fwd_o   = {^(x_i & TAPS), x_i[W-1:1]};
    // Upper predecessor bits are known directly; bit 0 is the only unknown, so mask it
    // out and solve the feedback equation for it.
    p_shift = {x_i[W-2:0], 1'b0};
    inv_o   = {x_i[W-2:0], x_i[W-1] ^ (^(p_shift & TAPS))};
  end

endmodule

// File: rtl/craft_rc_sequencer.sv
// CRAFT round-constant sequencer.
// Two Fibonacci LFSRs A and B emit RC = {A, 1'b0, B} once per round, forward
// (encrypt) or in reverse round order (decrypt), through a valid/ready handshake.
// clk, rst   clock; synchronous active-low reset
// rc_if      master side: start/dir/rc_ready in; rc_valid/rc_data/rc_last/
//            round_idx/busy/done out
module craft_rc_sequencer
  import craft_rc_pkg::*;
#(
  parameter int unsigned    A_W    = DefAW,
  parameter int unsigned    B_W    = DefBW,
  parameter logic [A_W-1:0] A_TAPS = A_W'(DefATaps),
  parameter logic [B_W-1:0] B_TAPS = B_W'(DefBTaps),
  parameter logic [A_W-1:0] A_SEED = A_W'(DefASeed),
  parameter logic [B_W-1:0] B_SEED = B_W'(DefBSeed),
  parameter int unsigned    ROUNDS = DefRounds
) (
  input logic                  clk,
  input logic                  rst,
  craft_rc_sequencer_if.master rc_if
);

  localparam int unsigned      RC_W  = A_W + 1 + B_W;
  localparam int unsigned      CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS - 1);
  // Inverse runs start where a forward run ends.
  localparam logic [A_W-1:0]   A_END = A_W'(lfsr_advance(32'(A_SEED), 32'(A_TAPS), A_W,
                                                         ROUNDS - 1));
  localparam logic [B_W-1:0]   B_END = B_W'(lfsr_advance(32'(B_SEED), 32'(B_TAPS), B_W,
                                                         ROUNDS - 1));

  seq_state_e       state_q, state_d;
  logic [A_W-1:0]   a_q, a_d, a_fwd, a_inv;
  logic [B_W-1:0]   b_q, b_d, b_fwd, b_inv;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             run, last, hs;
  logic [RC_W-1:0]  rc_data;

  craft_lfsr_step #(.W(A_W), .TAPS(A_TAPS)) u_step_a (
    .x_i  (a_q),
    .fwd_o(a_fwd),
    .inv_o(a_inv)
  );

  craft_lfsr_step #(.W(B_W), .TAPS(B_TAPS)) u_step_b (
    .x_i  (b_q),
    .fwd_o(b_fwd),
    .inv_o(b_inv)
  );

  always_comb begin
    run     = (state_q == StRun);
    last    = run && (cnt_q == LAST);
    hs      = run && rc_if.rc_ready;
    rc_data = {a_q, 1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rc_if.start) begin
          a_d     = rc_if.dir ? A_END : A_SEED;
          b_d     = rc_if.dir ? B_END : B_SEED;
          dir_d   = rc_if.dir;
          cnt_d   = '0;
          idx_d   = rc_if.dir ? LAST : '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (hs) begin
          if (last) begin
            // Final constant taken: LFSRs keep their value, done pulses next cycle.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            a_d   = dir_q ? a_inv : a_fwd;
            b_d   = dir_q ? b_inv : b_fwd;
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = dir_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= A_SEED;
      b_q     <= B_SEED;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rc_if.rc_valid  = run;
    rc_if.busy      = run;
    rc_if.rc_last   = last;
    rc_if.rc_data   = rc_data;
    rc_if.round_idx = idx_q;
    rc_if.done      = done_q;
  end

endmodule

// File: tb/tb_craft_rc_sequencer.sv
module tb_craft_rc_sequencer;

  localparam int unsigned R = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  craft_rc_sequencer_if #(.RcW(8), .CntW(5)) bus ();
  craft_rc_sequencer_if #(.RcW(9), .CntW(1)) bus2 ();

  craft_rc_sequencer u_dut (
    .clk  (clk),
    .rst  (rst),
    .rc_if(bus)
  );

  craft_rc_sequencer #(
    .A_W   (5),
    .A_TAPS(5'b00101),
    .A_SEED(5'h1),
    .ROUNDS(1)
  ) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .rc_if(bus2)
  );

  // Step units for the round-trip check.
  logic [3:0] x4, f4, r4, d4a, d4b;
  logic [2:0] x3, f3, r3, d3a, d3b;
  logic [4:0] x5, f5, r5, d5a, d5b;
  craft_lfsr_step #(.W(4), .TAPS(4'b0011))  u_s4f (.x_i(x4), .fwd_o(f4),  .inv_o(d4a));
  craft_lfsr_step #(.W(4), .TAPS(4'b0011))  u_s4i (.x_i(f4), .fwd_o(d4b), .inv_o(r4));
  craft_lfsr_step #(.W(3), .TAPS(3'b011))   u_s3f (.x_i(x3), .fwd_o(f3),  .inv_o(d3a));
  craft_lfsr_step #(.W(3), .TAPS(3'b011))   u_s3i (.x_i(f3), .fwd_o(d3b), .inv_o(r3));
  craft_lfsr_step #(.W(5), .TAPS(5'b00101)) u_s5f (.x_i(x5), .fwd_o(f5),  .inv_o(d5a));
  craft_lfsr_step #(.W(5), .TAPS(5'b00101)) u_s5i (.x_i(f5), .fwd_o(d5b), .inv_o(r5));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: forward-order constant table from plain LFSR arithmetic.
  int unsigned exp_rc[R];

  function automatic int unsigned fstep(input int unsigned x, input int unsigned taps,
                                        input int unsigned w);
    int unsigned fb;
    fb = $countones(x & taps) & 1;
    return (x >> 1) | (fb << (w - 1));
  endfunction

  // Protocol-level model: which constant of the run is on offer, whether a run is active.
  bit          mon_en = 1'b0;
  bit          m_run  = 1'b0;
  bit          m_dir  = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_k    = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      int unsigned r;
      chk("valid", longint'(bus.rc_valid), longint'(m_run));
      chk("busy", longint'(bus.busy), longint'(m_run));
      chk("done", longint'(bus.done), longint'(m_done));
      if (m_run) begin
        r = m_dir ? (R - 1 - m_k) : m_k;
        chk("rc_data", longint'(bus.rc_data), longint'(exp_rc[r]));
        chk("round_idx", longint'(bus.round_idx), longint'(r));
        chk("rc_last", longint'(bus.rc_last), longint'(m_k == R - 1));
      end else begin
        chk("rc_last_idle", longint'(bus.rc_last), 0);
      end
      if (!rst) begin
        m_run  = 1'b0;
        m_done = 1'b0;
      end else if (m_run) begin
        m_done = 1'b0;
        if (bus.rc_ready) begin
          if (m_k == R - 1) begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end else begin
            m_k++;
          end
        end
      end else begin
        m_done = 1'b0;
        if (bus.start) begin
          m_run = 1'b1;
          m_dir = bus.dir;
          m_k   = 0;
        end
      end
    end
  end

  logic [7:0] cap_q[$];
  logic [7:0] cap_fwd[$];
  logic [7:0] cap_inv[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Collect accepted constants until done, bounded.
  task automatic capture_run(input bit rand_ready);
    bit got;
    got = 1'b0;
    cap_q.delete();
    for (int c = 0; c < 600; c++) begin
      if (rand_ready) bus.rc_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.rc_valid && bus.rc_ready) cap_q.push_back(bus.rc_data);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("done_timeout", longint'(got), 1);
  endtask

  function automatic int seq_diff(input logic [7:0] a[$], input logic [7:0] b[$],
                                  input bit rev);
    int d;
    d = 0;
    if (a.size() != b.size()) return 1000;
    foreach (a[i]) if (a[i] !== (rev ? b[b.size() - 1 - i] : b[i])) d++;
    return d;
  endfunction

  initial begin
    int unsigned a, b;
    int hcount;
    a = 1;
    b = 1;
    for (int i = 0; i < R; i++) begin
      exp_rc[i] = (a << 4) | b;
      a = fstep(a, 4'b0011, 4);
      b = fstep(b, 3'b011, 3);
    end
    // Pin the model against hand-computed constants.
    chk("model_r0", longint'(exp_rc[0]), 'h11);
    chk("model_r4", longint'(exp_rc[4]), 'h96);

    bus.start = 0; bus.dir = 0; bus.rc_ready = 1;
    bus2.start = 0; bus2.dir = 0; bus2.rc_ready = 1;

    // Inverse undoes forward for every state.
    for (int x = 0; x < 16; x++) begin x4 = 4'(x); #1; chk("inv4", longint'(r4), x); end
    for (int x = 0; x < 8; x++)  begin x3 = 3'(x); #1; chk("inv3", longint'(r3), x); end
    for (int x = 0; x < 32; x++) begin x5 = 5'(x); #1; chk("inv5", longint'(r5), x); end
    x4 = 4'h1; x5 = 5'h1; #1;
    chk("fwd4_lit", longint'(f4), 'h8);
    chk("fwd5_lit", longint'(f5), 'h10);

    step(); step(); step();
    @(negedge clk);
    chk("rst_valid", longint'(bus.rc_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_last", longint'(bus.rc_last), 0);
    chk("rst_idx", longint'(bus.round_idx), 0);
    chk("rst_data", longint'(bus.rc_data), 'h11);
    mon_en = 1'b1;
    step();
    rst = 1'b1;
    step();

    // Forward, always ready.
    bus.start = 1; bus.dir = 0; step(); bus.start = 0;
    capture_run(1'b0);
    cap_fwd = cap_q;
    chk("fwd_count", longint'(cap_fwd.size()), R);
    if (cap_fwd.size() == R) begin
      chk("fwd_c0", longint'(cap_fwd[0]), 'h11);
      chk("fwd_c1", longint'(cap_fwd[1]), 'h84);
      chk("fwd_c2", longint'(cap_fwd[2]), 'h42);
      chk("fwd_c3", longint'(cap_fwd[3]), 'h25);
      chk("fwd_c4", longint'(cap_fwd[4]), 'h96);
    end
    step();
    @(negedge clk);
    chk("done_one_cycle", longint'(bus.done), 0);
    step();

    // Inverse, always ready.
    bus.start = 1; bus.dir = 1; step(); bus.start = 0; bus.dir = 0;
    capture_run(1'b0);
    cap_inv = cap_q;
    chk("inv_count", longint'(cap_inv.size()), R);
    if (cap_inv.size() == R) chk("inv_final", longint'(cap_inv[R - 1]), 'h11);
    chk("inv_is_reversed", seq_diff(cap_inv, cap_fwd, 1'b1), 0);
    step();

    // Forward with random backpressure.
    bus.start = 1; step(); bus.start = 0;
    capture_run(1'b1);
    chk("stall_seq", seq_diff(cap_q, cap_fwd, 1'b0), 0);
    step();
    bus.rc_ready = 1;
    step();

    // Reset in the middle of a run, at round 10.
    bus.start = 1; step(); bus.start = 0;
    hcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.rc_valid && bus.rc_ready) hcount++;
      if (hcount == 10) break;
      @(posedge clk);
      #1;
    end
    step();
    @(negedge clk);
    chk("at_round10", longint'(bus.round_idx), 10);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_valid", longint'(bus.rc_valid), 0);
    chk("mid_rst_busy", longint'(bus.busy), 0);
    chk("mid_rst_data", longint'(bus.rc_data), 'h11);
    step();
    rst = 1'b1;
    bus.start = 1; step(); bus.start = 0;
    @(negedge clk);
    chk("restart_first", longint'(bus.rc_data), 'h11);
    chk("restart_valid", longint'(bus.rc_valid), 1);
    step();
    capture_run(1'b0);
    chk("restart_tail", longint'(cap_q.size()), R - 1);
    step();

    // start held high with dir flipped during a run; chains into an inverse run on done.
    bus.start = 1; bus.dir = 0; step(); bus.dir = 1;
    capture_run(1'b0);
    chk("ignored_start_seq", seq_diff(cap_q, cap_fwd, 1'b0), 0);
    step();
    bus.start = 0; bus.dir = 0;
    capture_run(1'b0);
    chk("chained_inv_seq", seq_diff(cap_q, cap_inv, 1'b0), 0);
    step();

    // ROUNDS=1, A_W=5: first constant is also the last.
    for (int d = 0; d < 2; d++) begin
      bus2.start = 1; bus2.dir = 1'(d); step(); bus2.start = 0;
      @(negedge clk);
      chk("r1_valid", longint'(bus2.rc_valid), 1);
      chk("r1_last", longint'(bus2.rc_last), 1);
      chk("r1_data", longint'(bus2.rc_data), 'h011);
      chk("r1_idx", longint'(bus2.round_idx), 0);
      step();
      @(negedge clk);
      chk("r1_done", longint'(bus2.done), 1);
      chk("r1_valid_off", longint'(bus2.rc_valid), 0);
      step();
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
